// File: rtl/wb_tlb_seq.sv
// Multi-cycle TLB maintenance sequencer (TLBWR/TLBFILL/TLBRD/INVTLB) for the WB stage.
// Define TLB_LFSR_FILL_EN to pick TLBFILL slots with a 16-bit LFSR instead of round-robin.
module wb_tlb_seq #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [31:0]     req_pc,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic [88:0]     csr_entry,
  input  logic            estat_is_tlbr,
  output logic            busy,
  output logic            done,
  output logic            ine,
  output logic            w_we,
  output logic [IDXW-1:0] w_index,
  output logic [88:0]     w_entry,
  output logic [IDXW-1:0] r_index,
  input  logic [88:0]     r_entry,
  output logic            rd_valid,
  output logic [88:0]     rd_entry,
  output logic            refetch_valid,
  output logic [31:0]     refetch_pc
);

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_FILL = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_INV, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      op_reg;
  logic [4:0]      inv_op_reg;
  logic [9:0]      inv_asid_reg;
  logic [18:0]     inv_vppn_reg;
  logic [IDXW-1:0] index_reg;
  logic [88:0]     entry_reg;
  logic            tlbr_reg;
  logic [31:0]     refetch_pc_reg;
  logic [IDXW-1:0] ctr_reg;
  logic [88:0]     rd_entry_reg;
  logic [IDXW-1:0] fill_idx;
  logic            fill_step;
  logic            accept;
  logic            inv_nop;
  logic            inv_hit;
  logic            asid_hit;
  logic            va_hit;
  logic [18:0]     vppn_eq;

  assign accept    = (state_reg == S_IDLE) && req_valid;
  assign inv_nop   = (op_reg == OP_INV) && (inv_op_reg > 5'd6);
  assign fill_step = (state_reg == S_EXEC) && (op_reg == OP_FILL);

  // Entry under scan vs. latched INVTLB operands; huge pages (ps=21) ignore vppn[8:0].
  for (genvar gi = 0; gi < 19; gi++) begin : g_vppn_eq
    assign vppn_eq[gi] = (r_entry[69+gi] == inv_vppn_reg[gi]);
  end
  assign va_hit   = (r_entry[68:63] == 6'd21) ? &vppn_eq[18:9] : &vppn_eq;
  assign asid_hit = (r_entry[62:53] == inv_asid_reg);

  always_comb begin
    case (inv_op_reg)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = r_entry[52];
      5'd3:       inv_hit = !r_entry[52];
      5'd4:       inv_hit = !r_entry[52] && asid_hit;
      5'd5:       inv_hit = !r_entry[52] && asid_hit && va_hit;
      5'd6:       inv_hit = (r_entry[52] || asid_hit) && va_hit;
      default:    inv_hit = 1'b0;
    endcase
  end

`ifdef TLB_LFSR_FILL_EN
  logic [15:0] lfsr_reg;
  assign fill_idx = lfsr_reg[IDXW-1:0];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        lfsr_reg <= 16'hACE1;
    else if (fill_step) lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end
`else
  logic [IDXW-1:0] rr_reg;
  assign fill_idx = rr_reg;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        rr_reg <= '0;
    else if (fill_step) rr_reg <= (rr_reg == IDXW'(TLBNUM - 1)) ? '0 : rr_reg + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (req_valid) state_next = (req_op == OP_INV && inv_op <= 5'd6) ? S_INV : S_EXEC;
      S_EXEC: state_next = S_DONE;
      S_INV:  if (ctr_reg == IDXW'(TLBNUM - 1)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operands are captured once at acceptance so later CSR writes cannot disturb the op.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_reg         <= '0;
      inv_op_reg     <= '0;
      inv_asid_reg   <= '0;
      inv_vppn_reg   <= '0;
      index_reg      <= '0;
      entry_reg      <= '0;
      tlbr_reg       <= 1'b0;
      refetch_pc_reg <= '0;
      ctr_reg        <= '0;
      rd_entry_reg   <= '0;
    end else begin
      if (accept) begin
        op_reg         <= req_op;
        inv_op_reg     <= inv_op;
        inv_asid_reg   <= inv_asid;
        inv_vppn_reg   <= inv_vppn;
        index_reg      <= csr_index;
        entry_reg      <= csr_entry;
        tlbr_reg       <= estat_is_tlbr;
        refetch_pc_reg <= req_pc;
        ctr_reg        <= '0;
      end else if (state_reg == S_INV) begin
        ctr_reg <= ctr_reg + 1'b1;
      end
      if (state_reg == S_EXEC && op_reg == OP_RD)
        rd_entry_reg <= r_entry[88] ? r_entry : '0;
    end
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ine           = 1'b0;
    rd_valid      = 1'b0;
    refetch_valid = 1'b0;
    w_we          = 1'b0;
    w_index       = '0;
    w_entry       = '0;
    r_index       = index_reg;
    case (state_reg)
      S_IDLE: busy = req_valid;
      S_EXEC: begin
        busy = 1'b1;
        if (op_reg == OP_WR || op_reg == OP_FILL) begin
          w_we    = 1'b1;
          w_index = (op_reg == OP_FILL) ? fill_idx : index_reg;
          w_entry = {entry_reg[88] | tlbr_reg, entry_reg[87:0]};
        end
      end
      S_INV: begin
        busy    = 1'b1;
        r_index = ctr_reg;
        if (r_entry[88] && inv_hit) begin
          w_we    = 1'b1;
          w_index = ctr_reg;
          w_entry = {1'b0, r_entry[87:0]};
        end
      end
      S_DONE: begin
        done          = 1'b1;
        rd_valid      = (op_reg == OP_RD);
        ine           = inv_nop;
        refetch_valid = (op_reg == OP_WR) || (op_reg == OP_FILL) || (op_reg == OP_INV && !inv_nop);
      end
      default: ;
    endcase
  end

  assign rd_entry   = rd_entry_reg;
  assign refetch_pc = refetch_pc_reg;

endmodule

// File: tb/tb_wb_tlb_seq.sv
// Self-checking bench for wb_tlb_seq: behavioural TLB array plus write/read scoreboards.
module tb_wb_tlb_seq;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam logic [1:0] OP_WR = 2'd0, OP_FILL = 2'd1, OP_RD = 2'd2, OP_INV = 2'd3;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid = 1'b0;
  logic [1:0]      req_op = '0;
  logic [31:0]     req_pc = '0;
  logic [4:0]      inv_op = '0;
  logic [9:0]      inv_asid = '0;
  logic [18:0]     inv_vppn = '0;
  logic [IDXW-1:0] csr_index = '0;
  logic [88:0]     csr_entry = '0;
  logic            estat_is_tlbr = 1'b0;
  logic            busy, done, ine, w_we, rd_valid, refetch_valid;
  logic [IDXW-1:0] w_index, r_index;
  logic [88:0]     w_entry, r_entry, rd_entry;
  logic [31:0]     refetch_pc;

  always #5 clk = ~clk;

  wb_tlb_seq #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_index(csr_index),
    .csr_entry(csr_entry), .estat_is_tlbr(estat_is_tlbr), .busy(busy), .done(done), .ine(ine),
    .w_we(w_we), .w_index(w_index), .w_entry(w_entry), .r_index(r_index), .r_entry(r_entry),
    .rd_valid(rd_valid), .rd_entry(rd_entry), .refetch_valid(refetch_valid), .refetch_pc(refetch_pc)
  );

  // Behavioural TLB: bulk image load from the bench, otherwise DUT writes.
  logic [88:0] tlb [TLBNUM];
  logic [88:0] img [TLBNUM];
  logic        load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= img[i];
    end else if (w_we) begin
      tlb[w_index] <= w_entry;
    end
  end
  assign r_entry = tlb[r_index];

  typedef struct packed {logic [IDXW-1:0] idx; logic [88:0] ent;} wr_t;
  wr_t         exp_wr[$];
  logic [88:0] exp_rd[$];
  wr_t         mon_w;
  logic [88:0] mon_r;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic [IDXW-1:0] rr_m = '0;

  always @(negedge clk) begin
    if (w_we === 1'b1) begin
      n_tests++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got idx=%0d entry=%h, required no write", w_index, w_entry);
      end else begin
        mon_w = exp_wr.pop_front();
        $display("[TB] write idx=%0d entry=%h", w_index, w_entry);
        if (w_index !== mon_w.idx || w_entry !== mon_w.ent) begin
          n_fail++;
          $display("FAIL wr_data: got idx=%0d entry=%h, required idx=%0d entry=%h",
                   w_index, w_entry, mon_w.idx, mon_w.ent);
        end
      end
    end
    if (rd_valid === 1'b1) begin
      n_tests++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_entry=%h, required no rd_valid", rd_entry);
      end else begin
        mon_r = exp_rd.pop_front();
        $display("[TB] tlbrd rd_entry=%h", rd_entry);
        if (rd_entry !== mon_r) begin
          n_fail++;
          $display("FAIL rd_data: got %h, required %h", rd_entry, mon_r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                     input logic [9:0] asid, input logic g);
    logic [25:0] lo0, lo1;
    lo0 = 26'($urandom);
    lo1 = 26'($urandom);
    return {e, vppn, ps, asid, g, lo0, lo1};
  endfunction

  // Reference INVTLB match rule, written from the architectural definition.
  function automatic logic model_hit(input logic [4:0] op, input logic [9:0] asid,
                                     input logic [18:0] vppn, input logic [88:0] ent);
    logic g, am, vm;
    g  = ent[52];
    am = (ent[62:53] == asid);
    vm = (ent[68:63] == 6'd21) ? (ent[87:78] == vppn[18:9]) : (ent[87:69] == vppn);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return g;
      5'd3: return !g;
      5'd4: return !g && am;
      5'd5: return !g && am && vm;
      5'd6: return (g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_img();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  // Presents one request for exactly one cycle, then scrambles the CSR inputs.
  task automatic issue(input logic [1:0] op, input logic [IDXW-1:0] idx, input logic [88:0] ent,
                       input logic tlbr, input logic [4:0] iop, input logic [9:0] asid,
                       input logic [18:0] vppn, input logic [31:0] pc);
    @(posedge clk); #1;
    req_op = op; csr_index = idx; csr_entry = ent; estat_is_tlbr = tlbr;
    inv_op = iop; inv_asid = asid; inv_vppn = vppn; req_pc = pc; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    csr_index = IDXW'($urandom);
    csr_entry = {25'($urandom), $urandom, $urandom};
    estat_is_tlbr = 1'($urandom);
    inv_asid = 10'($urandom);
    inv_vppn = 19'($urandom);
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({busy, done, ine, w_we, rd_valid, refetch_valid} !== 6'b0 || w_index !== '0 || w_entry !== '0
        || rd_entry !== '0 || refetch_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b ine=%b we=%b rdv=%b rfv=%b widx=%0d went=%h rd=%h pc=%h, required all 0",
               busy, done, ine, w_we, rd_valid, refetch_valid, w_index, w_entry, rd_entry, refetch_pc);
    end
    req_valid = 1'b1; #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_follows: got %b, required 1", busy); end
    req_valid = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_tlbwr();
    logic [88:0] ent;
    ent = mk(1'b1, 19'h01234, 6'd12, 10'h055, 1'b0);
    exp_wr.push_back(wr_t'{4'd5, ent});
    issue(OP_WR, 4'd5, ent, 1'b0, 5'd0, 10'd0, 19'd0, 32'h1c00_0100);
    @(negedge clk);
    n_tests++;
    if (w_we !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL wr_t1: got we=%b done=%b, required we=1 done=0", w_we, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || refetch_valid !== 1'b1 || refetch_pc !== 32'h1c00_0100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: got done=%b rfv=%b pc=%h busy=%b, required 1 1 1c000100 0",
               done, refetch_valid, refetch_pc, busy);
    end
  endtask

  task automatic test_tlbr_force();
    logic [88:0] ent;
    for (int t = 1; t >= 0; t--) begin
      ent = mk(1'b0, 19'h00777, 6'd12, 10'h033, 1'b1);
      exp_wr.push_back(wr_t'{IDXW'(6 + t), {1'(t), ent[87:0]}});
      issue(OP_WR, IDXW'(6 + t), ent, 1'(t), 5'd0, 10'd0, 19'd0, 32'h1c00_0200);
      @(negedge clk);
      n_tests++;
      if (w_entry[88] !== 1'(t)) begin
        n_fail++; $display("FAIL wr_tlbr_e: got e=%b, required %0d", w_entry[88], t);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tlbrd();
    for (int i = 0; i < TLBNUM; i++) img[i] = mk(1'b0, 19'(i), 6'd12, 10'(i), 1'b0);
    img[3] = mk(1'b1, 19'h0abcd, 6'd12, 10'h101, 1'b1);
    load_img();
    for (int k = 3; k <= 4; k++) begin
      exp_rd.push_back(k == 3 ? img[3] : 89'b0);
      issue(OP_RD, IDXW'(k), 89'b0, 1'b0, 5'd0, 10'd0, 19'd0, 32'h1c00_0300);
      @(negedge clk);
      n_tests++;
      if (w_we !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++; $display("FAIL rd_t1: got we=%b rdv=%b, required 0 0", w_we, rd_valid);
      end
      @(negedge clk);
      n_tests++;
      if (rd_valid !== 1'b1 || done !== 1'b1 || refetch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_done: got rdv=%b done=%b rfv=%b, required 1 1 0", rd_valid, done, refetch_valid);
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_entry !== 89'b0) begin n_fail++; $display("FAIL rd_hold: got %h, required 0", rd_entry); end
  endtask

  task automatic test_invtlb_op5();
    int nbusy;
    img[0] = mk(1'b1, 19'h00400, 6'd12, 10'h012, 1'b0);
    img[1] = mk(1'b1, 19'h00400, 6'd12, 10'h012, 1'b1);
    img[2] = mk(1'b1, 19'h005FF, 6'd21, 10'h012, 1'b0);
    img[3] = mk(1'b1, 19'h005FF, 6'd12, 10'h012, 1'b0);
    img[4] = mk(1'b1, 19'h00400, 6'd12, 10'h013, 1'b0);
    img[5] = mk(1'b0, 19'h00400, 6'd12, 10'h012, 1'b0);
    for (int i = 6; i < TLBNUM; i++) img[i] = mk(1'b1, (i % 2) ? 19'h00400 : 19'h00401, 6'd12, 10'h012, 1'b0);
    load_img();
    for (int i = 0; i < TLBNUM; i++)
      if (img[i][88] && model_hit(5'd5, 10'h012, 19'h00400, img[i]))
        exp_wr.push_back(wr_t'{IDXW'(i), {1'b0, img[i][87:0]}});
    issue(OP_INV, 4'd0, 89'b0, 1'b0, 5'd5, 10'h012, 19'h00400, 32'h1c00_0400);
    nbusy = 1;  // acceptance cycle
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      nbusy++;
    end
    n_tests++;
    if (nbusy != TLBNUM + 1) begin n_fail++; $display("FAIL inv_busy_len: got %0d, required %0d", nbusy, TLBNUM + 1); end
    n_tests++;
    if (done !== 1'b1 || refetch_valid !== 1'b1 || ine !== 1'b0) begin
      n_fail++; $display("FAIL inv_done: got done=%b rfv=%b ine=%b, required 1 1 0", done, refetch_valid, ine);
    end
    n_tests++;
    if (tlb[1] !== img[1] || tlb[2][88] !== 1'b0 || tlb[3] !== img[3]) begin
      n_fail++; $display("FAIL inv_table: got e1=%b e2=%b e3=%b, required 1 0 1", tlb[1][88], tlb[2][88], tlb[3][88]);
    end
  endtask

  task automatic test_inv_op7();
    issue(OP_INV, 4'd0, 89'b0, 1'b0, 5'd7, 10'h012, 19'h00400, 32'h1c00_0500);
    @(negedge clk);
    n_tests++;
    if (w_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL ine_t1: got we=%b busy=%b done=%b, required 0 1 0", w_we, busy, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || ine !== 1'b1 || refetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL ine_done: got done=%b ine=%b rfv=%b, required 1 1 0", done, ine, refetch_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [88:0] ent;
    ent = mk(1'b1, 19'h00099, 6'd12, 10'h009, 1'b0);
    exp_wr.push_back(wr_t'{4'd9, ent});
    issue(OP_WR, 4'd9, ent, 1'b0, 5'd0, 10'd0, 19'd0, 32'h1c00_0600);
    @(posedge clk); #1;  // DONE cycle: present a request that must be dropped
    req_op = OP_WR; csr_index = 4'd10; csr_entry = ent; req_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: got done=%b busy=%b, required 1 0", done, busy);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (w_we !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL b2b_ignored: got we=%b busy=%b, required 0 0", w_we, busy);
      end
    end
  endtask

  task automatic test_fill();
    logic [88:0] ent;
    logic [IDXW-1:0] eidx;
    for (int k = 0; k < 4; k++) begin
`ifdef TLB_LFSR_FILL_EN
      eidx   = lfsr_m[IDXW-1:0];
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
      eidx = rr_m;
      rr_m = rr_m + 1'b1;
`endif
      ent = mk(1'b1, 19'(k * 7), 6'd12, 10'(k), 1'b0);
      exp_wr.push_back(wr_t'{eidx, ent});
      issue(OP_FILL, IDXW'($urandom), ent, 1'b0, 5'd0, 10'd0, 19'd0, 32'h1c00_0700 + 32'(k * 4));
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || refetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL fill_done: got done=%b rfv=%b, required 1 1", done, refetch_valid);
      end
    end
  endtask

  task automatic test_reset_mid_inv();
    int untouched, cleared;
    for (int i = 0; i < TLBNUM; i++) img[i] = mk(1'b1, 19'(i), 6'd12, 10'(i), 1'b0);
    load_img();
    for (int i = 0; i < 5; i++) exp_wr.push_back(wr_t'{IDXW'(i), {1'b0, img[i][87:0]}});
    issue(OP_INV, 4'd0, 89'b0, 1'b0, 5'd0, 10'd0, 19'd0, 32'h1c00_0800);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    resetn = 1'b0; #1;
    n_tests++;
    if (w_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_inv: got we=%b busy=%b done=%b, required 0 0 0", w_we, busy, done);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    untouched = 0; cleared = 0;
    for (int i = 0; i < 5; i++) if (tlb[i][88] === 1'b0) cleared++;
    for (int i = 5; i < TLBNUM; i++) if (tlb[i] === img[i]) untouched++;
    n_tests++;
    if (cleared != 5 || untouched != TLBNUM - 5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_table: got cleared=%0d untouched=%0d busy=%b, required 5 %0d 0",
               cleared, untouched, busy, TLBNUM - 5);
    end
  endtask

  initial begin
    test_reset();
    test_tlbwr();
    test_tlbr_force();
    test_tlbrd();
    test_invtlb_op5();
    test_inv_op7();
    test_back_to_back();
    test_fill();
    test_reset_mid_inv();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d writes %0d reads pending, required 0 0", exp_wr.size(), exp_rd.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
